// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the LEGv8 datapath and pipe_hazard_ctrl.
//   master : datapath side. It drives the hazard sources (ID operands, EX load
//            info, branch resolution, MEM handshake) and receives the
//            per-register enable/flush/bubble controls.
//   slave  : controller side, with the directions reversed.
interface pipe_hazard_ctrl_if;
  // hazard sources
  logic [4:0] id_Rn;
  logic [4:0] id_Rm;
  logic       id_uses_Rn;
  logic       id_uses_Rm;
  logic       ex_MemRead;
  logic [4:0] ex_Rd;
  logic       br_taken;
  logic       mem_req;
  logic       mem_ready;
  // pipeline register controls
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_bubble;
  logic       exmem_en;
  logic       memwr_en;
  logic       memwr_bubble;
  logic       stall;
  logic       timeout_err;

  modport master (
    output id_Rn, id_Rm, id_uses_Rn, id_uses_Rm, ex_MemRead, ex_Rd,
           br_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           memwr_en, memwr_bubble, stall, timeout_err
  );

  modport slave (
    input  id_Rn, id_Rm, id_uses_Rn, id_uses_Rm, ex_MemRead, ex_Rd,
           br_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           memwr_en, memwr_bubble, stall, timeout_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage LEGv8 pipeline.
// It handles three cases:
//   - load-use hazards: a one-cycle front stall with a bubble into ID/EX
//   - taken branches resolved in ID: a one-cycle IF/ID flush
//   - variable-latency data-memory accesses: a pipeline freeze that ends in a
//     sticky error if MEM_TIMEOUT wait cycles pass without mem_ready
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   hz         : pipe_hazard_ctrl_if.slave. Carries the hazard sources in and
//                the PC/IF-ID/ID-EX/EX-MEM/MEM-WR controls, stall and
//                timeout_err out.
//   stall_cnt, flush_cnt : saturating performance counters. These ports exist
//                only when the PIPE_PERF_EN macro is defined.
// Outputs are combinational from state and inputs. State changes only on
// posedge clk.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [4:0]  ZERO_REG    = 5'd31
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t     state, state_n;
  logic [7:0] wcnt, wcnt_n;
  logic       terr, terr_n;
  logic       lu;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic exmem_en, memwr_en, memwr_bubble, stall;

  // XZR never creates a dependency, even when a load names it as its target.
  always_comb begin
    lu = hz.ex_MemRead && (hz.ex_Rd != ZERO_REG) &&
         ((hz.id_uses_Rn && (hz.id_Rn == hz.ex_Rd)) ||
          (hz.id_uses_Rm && (hz.id_Rm == hz.ex_Rd)));
  end

  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    terr_n       = terr;
    // normal RUN behaviour, including the load-use stall and the branch flush
    pc_en        = ~lu;
    ifid_en      = ~lu;
    ifid_flush   = hz.br_taken & ~lu;
    idex_en      = 1'b1;
    idex_bubble  = lu;
    exmem_en     = 1'b1;
    memwr_en     = 1'b1;
    memwr_bubble = 1'b0;
    stall        = lu;

    case (state)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          // A memory wait takes priority over lu and the branch. Both are
          // re-evaluated on the release cycle, because ID is frozen until then.
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          ifid_flush   = 1'b0;
          idex_en      = 1'b0;
          idex_bubble  = 1'b0;
          exmem_en     = 1'b0;
          memwr_bubble = 1'b1;
          stall        = 1'b1;
          state_n      = MEM_WAIT;
          wcnt_n       = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          // release cycle: the outputs are the RUN outputs computed above
          state_n = RUN;
          wcnt_n  = 8'd0;
        end else begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          ifid_flush   = 1'b0;
          idex_en      = 1'b0;
          idex_bubble  = 1'b0;
          exmem_en     = 1'b0;
          memwr_bubble = 1'b1;
          stall        = 1'b1;
          if (wcnt < TO) begin
            wcnt_n = wcnt + 8'd1;
          end else begin
            state_n = ERR;
            terr_n  = 1'b1;
          end
        end
      end
      ERR: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b0;
        memwr_en     = 1'b0;
        memwr_bubble = 1'b1;
        stall        = 1'b1;
      end
      default: begin
        state_n = RUN;
        wcnt_n  = 8'd0;
      end
    endcase

    // While reset is high every register loads NOP/bubble and nothing advances.
    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_en      = 1'b0;
      idex_bubble  = 1'b1;
      exmem_en     = 1'b0;
      memwr_en     = 1'b0;
      memwr_bubble = 1'b1;
      stall        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wcnt  <= 8'd0;
      terr  <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      terr  <= terr_n;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwr_en     = memwr_en;
  assign hz.memwr_bubble = memwr_bubble;
  assign hz.stall        = stall;
  assign hz.timeout_err  = terr;

`ifdef PIPE_PERF_EN
  // Saturating event counters. The reset branch wins, so the forced
  // stall/flush values shown during reset are never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. It is built with MEM_TIMEOUT=4.
// Each step drives the inputs on the falling edge and pushes the expected
// control vector into a scoreboard. One time unit later it pops that entry
// and compares it against the DUT outputs.
// Vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
//                memwr_en, memwr_bubble, stall, timeout_err}
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus();

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .ZERO_REG(5'd31)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus.slave)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  localparam logic [9:0] V_RST   = 10'b0010100110;
  localparam logic [9:0] V_RSTE  = 10'b0010100111;
  localparam logic [9:0] V_RUN   = 10'b1101011000;
  localparam logic [9:0] V_LU    = 10'b0001111010;
  localparam logic [9:0] V_BR    = 10'b1111011000;
  localparam logic [9:0] V_FRZ   = 10'b0000001110;
  localparam logic [9:0] V_ERR   = 10'b0000000111;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  function automatic logic [9:0] observe();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_bubble,
            bus.exmem_en, bus.memwr_en, bus.memwr_bubble, bus.stall, bus.timeout_err};
  endfunction

  // One cycle: drive the inputs, push the expected vector, then compare.
  task automatic step(input string tag, input logic rst,
                      input logic mr, input logic [4:0] rd,
                      input logic urn, input logic [4:0] rn,
                      input logic urm, input logic [4:0] rm,
                      input logic br, input logic req, input logic rdy,
                      input logic [9:0] exp);
    sb_t        e;
    logic [9:0] obs;
    @(negedge clk);
    reset          = rst;
    bus.ex_MemRead = mr;
    bus.ex_Rd      = rd;
    bus.id_uses_Rn = urn;
    bus.id_Rn      = rn;
    bus.id_uses_Rm = urm;
    bus.id_Rm      = rm;
    bus.br_taken   = br;
    bus.mem_req    = req;
    bus.mem_ready  = rdy;
    sb.push_back('{tag, exp});
    #1;
    obs = observe();
    e   = sb.pop_front();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  task automatic idle(input string tag, input logic [9:0] exp);
    step(tag, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic mem(input string tag, input logic rdy, input logic [9:0] exp);
    step(tag, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, rdy, exp);
  endtask

  initial begin
    // Reset is high before the first edge, so the state register is defined
    // by the time of the first sample.
    reset = 1'b1;
    bus.ex_MemRead = 1'b0; bus.ex_Rd = 5'd0; bus.id_uses_Rn = 1'b0; bus.id_Rn = 5'd0;
    bus.id_uses_Rm = 1'b0; bus.id_Rm = 5'd0; bus.br_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

    step("reset_c1", 1'b1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, V_RST);
    step("reset_c2", 1'b1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, V_RST);
    idle("run_after_reset", V_RUN);

    // load-use through Rm, Rn, and the XZR / unused-operand exclusions
    step("lu_rm",       0, 1, 5'd5,  0, 5'd0, 1, 5'd5,  0, 0, 0, V_LU);
    idle("lu_one_cycle", V_RUN);
    step("lu_xzr",      0, 1, 5'd31, 0, 5'd0, 1, 5'd31, 0, 0, 0, V_RUN);
    step("lu_rn",       0, 1, 5'd7,  1, 5'd7, 0, 5'd0,  0, 0, 0, V_LU);
    step("lu_rn_unused",0, 1, 5'd7,  0, 5'd7, 0, 5'd0,  0, 0, 0, V_RUN);
    step("no_load",     0, 0, 5'd7,  1, 5'd7, 1, 5'd7,  0, 0, 0, V_RUN);

    // branch flush, and branch suppressed by load-use
    step("br_flush",    0, 0, 5'd0,  0, 5'd0, 0, 5'd0,  1, 0, 0, V_BR);
    idle("br_one_cycle", V_RUN);
    step("br_with_lu",  0, 1, 5'd5,  0, 5'd0, 1, 5'd5,  1, 0, 0, V_LU);
    step("br_reeval",   0, 0, 5'd0,  0, 5'd0, 0, 5'd0,  1, 0, 0, V_BR);

    // 3 freeze cycles, then release
    mem("mw_entry", 0, V_FRZ);
    mem("mw_wait1", 0, V_FRZ);
    mem("mw_wait2", 0, V_FRZ);
    mem("mw_release", 1, V_RUN);
    idle("mw_after", V_RUN);

    // a memory wait overrides lu and the branch; the release re-evaluates them
    step("mw_over_lu_br", 0, 1, 5'd5, 0, 5'd0, 1, 5'd5, 1, 1, 0, V_FRZ);
    step("mw_rel_lu_br",  0, 1, 5'd5, 0, 5'd0, 1, 5'd5, 1, 1, 1, V_LU);
    idle("after_rel_lu", V_RUN);
    mem("req_and_ready", 1, V_RUN);

    // timeout: one entry cycle plus 4 wait cycles, then ERR
    mem("to_entry", 0, V_FRZ);
    mem("to_wait1", 0, V_FRZ);
    mem("to_wait2", 0, V_FRZ);
    mem("to_wait3", 0, V_FRZ);
    mem("to_wait4", 0, V_FRZ);
    mem("err_hold", 0, V_ERR);
    mem("err_ignores_ready", 1, V_ERR);
    idle("err_sticky", V_ERR);
    step("reset_from_err", 1'b1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, V_RSTE);
    idle("run_after_err", V_RUN);

    // reset asserted on the 2nd MEM_WAIT cycle
    mem("mr_entry", 0, V_FRZ);
    mem("mr_wait1", 0, V_FRZ);
    step("mr_reset", 1'b1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, V_RST);
    idle("mr_run", V_RUN);
`ifdef PIPE_PERF_EN
    checks++;
    assert (stall_cnt === 32'd0) else begin
      errors++;
      $error("FAIL stall_cnt_reset: observed %0d expected 0", stall_cnt);
    end
    checks++;
    assert (flush_cnt === 32'd0) else begin
      errors++;
      $error("FAIL flush_cnt_reset: observed %0d expected 0", flush_cnt);
    end
`endif
    // After the reset, a wait of 3 cycles must release cleanly.
    mem("mr2_entry", 0, V_FRZ);
    mem("mr2_wait1", 0, V_FRZ);
    mem("mr2_wait2", 0, V_FRZ);
    mem("mr2_release", 1, V_RUN);
`ifdef PIPE_PERF_EN
    checks++;
    assert (stall_cnt === 32'd3) else begin
      errors++;
      $error("FAIL stall_cnt_count: observed %0d expected 3", stall_cnt);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage LEGv8 pipeline. Drives the enable, flush and bubble controls of the PC and all four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WR). Covers three cases: load-use hazards, taken branches resolved in ID, and variable-latency data-memory accesses with a timeout. Sits beside the datapath; all outputs go directly to the pipeline register instances.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive wait cycles tolerated for one data-memory access before an error (legal range 1..255).
ZERO_REG, 31, register index of XZR; never a hazard source.

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
id_Rn  input  5  first source register of the instruction in ID
id_Rm  input  5  second source register of the instruction in ID
id_uses_Rn  input  1  ID instruction reads id_Rn
id_uses_Rm  input  1  ID instruction reads id_Rm
ex_MemRead  input  1  instruction in EX is a load
ex_Rd  input  5  destination register of the instruction in EX
br_taken  input  1  branch in ID resolved taken this cycle
mem_req  input  1  instruction in MEM performs a data-memory access
mem_ready  input  1  data memory completes the access this cycle
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID register load enable
ifid_flush  output  1  load NOP into IF/ID (valid only when ifid_en=1)
idex_en  output  1  ID/EX register load enable
idex_bubble  output  1  load control-zero bubble into ID/EX
exmem_en  output  1  EX/MEM register load enable
memwr_en  output  1  MEM/WR register load enable
memwr_bubble  output  1  load bubble (RegWE=0) into MEM/WR
stall  output  1  status: pipeline front is not advancing this cycle
timeout_err  output  1  sticky memory-timeout error flag

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. A wait counter wcnt (8 bit) tracks MEM_WAIT cycles.
- Reset state: state=RUN, wcnt=0, timeout_err=0.
- Outputs while reset=1: all enables 0, ifid_flush=1, idex_bubble=1, memwr_bubble=1, stall=1.
- Default in RUN: all enables 1, all flush/bubble 0, stall=0.
- Load-use hazard (lu):
  - lu = ex_MemRead & ex_Rd!=ZERO_REG & ((id_uses_Rn & id_Rn==ex_Rd) | (id_uses_Rm & id_Rm==ex_Rd)).
  - Action: pc_en=0, ifid_en=0, idex_bubble=1, stall=1. Later stages advance.
  - Lasts exactly one cycle: the bubble clears ex_MemRead.
- Branch flush: br_taken & ~lu -> ifid_flush=1 with ifid_en=1, for one cycle.
- Branch with lu: flush is suppressed. The branch stays in ID and is re-evaluated next cycle.
- Memory wait:
  - Entry: in RUN, mem_req & ~mem_ready -> freeze. pc_en, ifid_en, idex_en, exmem_en all 0; memwr_en=1, memwr_bubble=1; stall=1; next state MEM_WAIT, wcnt=1.
  - Priority: a memory wait overrides lu and br_taken. Both are re-evaluated after release.
  - mem_req & mem_ready in the same RUN cycle: no wait; normal RUN outputs.
  - MEM_WAIT with mem_ready=1: release cycle. Outputs equal RUN outputs, including lu and branch evaluation. Next state RUN, wcnt=0.
  - MEM_WAIT with mem_ready=0 and wcnt<MEM_TIMEOUT: freeze outputs as at entry; wcnt+1.
  - MEM_WAIT with mem_ready=0 and wcnt==MEM_TIMEOUT: freeze outputs; next state ERR, timeout_err<=1.
- ERR: all enables 0, memwr_bubble=1, stall=1. Held until reset; timeout_err stays 1.
- Reset in any state, including mid-wait, returns to RUN on the next edge. No in-flight access is remembered.
- Outputs are combinational from state and inputs. Internal state changes only on posedge clk.

Optional Feature:
PIPE_PERF_EN
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on every cycle with stall=1 and reset=0.
  - flush_cnt increments on every cycle with ifid_flush=1 and reset=0.
  - Both saturate at 32'hFFFFFFFF and clear to 0 on reset.
- Undefined: the counters are not built and the ports are absent. Core behaviour is identical in both builds.

Test Plan:
- Hold reset 2 cycles then release, no hazards -> during reset enables 0 and all bubbles/flush 1; after reset all enables 1, stall=0, timeout_err=0.
- ex_MemRead=1, ex_Rd=5, id_uses_Rm=1, id_Rm=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1. Repeat with ex_Rd=id_Rm=31 -> no stall.
- br_taken=1 alone -> ifid_flush=1 for 1 cycle. br_taken=1 with the load-use condition above -> ifid_flush=0, stall=1.
- mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 freeze cycles (exmem_en=0, memwr_bubble=1), then a release cycle with all enables 1, state RUN.
- MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> after 1 entry cycle and 4 wait cycles, timeout_err=1 and ERR holds. Assert reset -> RUN, timeout_err=0.
- Reset asserted on the 2nd MEM_WAIT cycle -> next cycle in RUN, wcnt=0. With PIPE_PERF_EN, stall_cnt=0 after reset.
